// File: rtl/bram_mask_loader_if.sv
// Mask stream interface: 16-bit AXI-stream carrying a mask image.
//   tdata  : mask word
//   tvalid : beat valid (driven by master)
//   tready : beat ready (driven by slave)
//   tlast  : last word of the mask frame
//   tuser  : first word of the mask frame
interface bram_mask_loader_if #(
    parameter int unsigned DW = 16
) ();
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/bram_mask_loader.sv
// Mask loader: packs pairs of 16-bit stream words into 32-bit words and writes them into one of
// two mask BRAMs (first word -> [31:16], second -> [15:0], byte address steps by 4).
//
// Ports:
//   clk, rst (sync, active-low)    clock and reset
//   bank_sel                       target bank, latched on the start-of-frame beat
//   m_s                            mask stream (slave side)
//   bram_{rst,clk,en,we,addr,din}0/1  BRAM write ports, bank 0 and bank 1
//   frame_done                     one-cycle pulse when a frame completes
//   words_written                  16-bit words in the last completed frame (saturating)
//   overflow                       last frame ran past DEPTH_WORDS
//   busy                           frame in progress
//
// Option macro MASK_BYTE_WE_EN: 4-bit byte write enables; the trailing odd word is written with
// 4'b1100 so the low half of the BRAM word is preserved. Undefined: 1-bit we, low half zero-filled.
module bram_mask_loader #(
    parameter int unsigned DW          = 16,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bank_sel,
    bram_mask_loader_if.slave m_s,
    output logic              bram_rst0,
    output logic              bram_rst1,
    output logic              bram_clk0,
    output logic              bram_clk1,
    output logic              bram_en0,
    output logic              bram_en1,
`ifdef MASK_BYTE_WE_EN
    output logic [3:0]        bram_we0,
    output logic [3:0]        bram_we1,
`else
    output logic              bram_we0,
    output logic              bram_we1,
`endif
    output logic [31:0]       bram_addr0,
    output logic [31:0]       bram_addr1,
    output logic [31:0]       bram_din0,
    output logic [31:0]       bram_din1,
    output logic              frame_done,
    output logic [15:0]       words_written,
    output logic              overflow,
    output logic              busy
);

`ifdef MASK_BYTE_WE_EN
    localparam int unsigned    WeW     = 4;
    localparam logic [WeW-1:0] WeFull  = 4'b1111;
    localparam logic [WeW-1:0] WeFlush = 4'b1100;
`else
    localparam int unsigned    WeW     = 1;
    localparam logic [WeW-1:0] WeFull  = 1'b1;
    localparam logic [WeW-1:0] WeFlush = 1'b1;
`endif
    localparam logic [31:0] AddrLimit = 32'(DEPTH_WORDS * 4);

    typedef enum logic [2:0] {StIdle, StEven, StOdd, StFlush, StDone} state_e;

    state_e         state_q, state_d;
    logic [DW-1:0]  hi_q, hi_d;
    logic [31:0]    addr_q, addr_d;     // address of the next write
    logic [15:0]    count_q, count_d;
    logic           bank_q, bank_d;
    logic           ovf_q, ovf_d;
    logic           en0_q, en0_d, en1_q, en1_d;
    logic [WeW-1:0] we0_q, we0_d, we1_q, we1_d;
    logic [31:0]    wa_q, wa_d, wd_q, wd_d;
    logic           done_q, done_d;
    logic [15:0]    ww_q, ww_d;
    logic           tready_q, tready_d;
    logic           busy_q, busy_d;

    logic           accept;
    logic           wr_req;
    logic [WeW-1:0] wr_we;
    logic [31:0]    wr_data;

    always_comb begin
        accept  = m_s.tvalid && tready_q;
        state_d = state_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        count_d = count_q;
        bank_d  = bank_q;
        ovf_d   = ovf_q;
        en0_d   = 1'b0;
        en1_d   = 1'b0;
        we0_d   = '0;
        we1_d   = '0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wr_req  = 1'b0;
        wr_we   = WeFull;
        wr_data = '0;

        case (state_q)
            StIdle, StEven, StOdd: begin
                // In IDLE only a start-of-frame beat is taken; others are dropped.
                if (accept && (m_s.tuser || state_q != StIdle)) begin
                    if (m_s.tuser) begin
                        // Start or restart: any pending high half is simply forgotten.
                        bank_d  = bank_sel;
                        addr_d  = '0;
                        ovf_d   = 1'b0;
                        count_d = 16'd1;
                    end else if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end

                    if (m_s.tuser || state_q == StEven) begin
                        hi_d = m_s.tdata;
                        if (m_s.tlast) begin
                            // Trailing odd word: registered now, so it lands during FLUSH.
                            wr_req  = 1'b1;
                            wr_we   = WeFlush;
                            wr_data = {m_s.tdata, {DW{1'b0}}};
                            state_d = StFlush;
                        end else begin
                            state_d = StOdd;
                        end
                    end else begin
                        wr_req  = 1'b1;
                        wr_data = {hi_q, m_s.tdata};
                        state_d = m_s.tlast ? StDone : StEven;
                    end
                end
            end
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (wr_req) begin
            if (addr_d == AddrLimit) begin
                ovf_d = 1'b1;
            end else begin
                en0_d  = ~bank_d;
                en1_d  = bank_d;
                we0_d  = bank_d ? '0 : wr_we;
                we1_d  = bank_d ? wr_we : '0;
                wa_d   = addr_d;
                wd_d   = wr_data;
                addr_d = addr_d + 32'd4;
            end
        end

        done_d   = (state_d == StDone);
        ww_d     = done_d ? count_d : ww_q;
        tready_d = (state_d inside {StIdle, StEven, StOdd});
        busy_d   = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            hi_q     <= '0;
            addr_q   <= '0;
            count_q  <= '0;
            bank_q   <= 1'b0;
            ovf_q    <= 1'b0;
            en0_q    <= 1'b0;
            en1_q    <= 1'b0;
            we0_q    <= '0;
            we1_q    <= '0;
            wa_q     <= '0;
            wd_q     <= '0;
            done_q   <= 1'b0;
            ww_q     <= '0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            bank_q   <= bank_d;
            ovf_q    <= ovf_d;
            en0_q    <= en0_d;
            en1_q    <= en1_d;
            we0_q    <= we0_d;
            we1_q    <= we1_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            done_q   <= done_d;
            ww_q     <= ww_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
        end
    end

    assign m_s.tready    = tready_q;
    assign bram_rst0     = ~rst;
    assign bram_rst1     = ~rst;
    assign bram_clk0     = clk;
    assign bram_clk1     = clk;
    assign bram_en0      = en0_q;
    assign bram_en1      = en1_q;
    assign bram_we0      = we0_q;
    assign bram_we1      = we1_q;
    assign bram_addr0    = wa_q;
    assign bram_addr1    = wa_q;
    assign bram_din0     = wd_q;
    assign bram_din1     = wd_q;
    assign frame_done    = done_q;
    assign words_written = ww_q;
    assign overflow      = ovf_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_bram_mask_loader.sv
// Self-checking bench for bram_mask_loader. Two instances: dut0 (DEPTH_WORDS=1024) and
// dut1 (DEPTH_WORDS=2, for overflow). Expected BRAM writes are queued as each beat is
// accepted and checked by a write monitor, including the cycle the write must appear in.
module tb_bram_mask_loader;

`ifdef MASK_BYTE_WE_EN
    localparam int          WEW        = 4;
    localparam logic [3:0]  WE_FULL    = 4'hF;
    localparam logic [3:0]  WE_FLUSH   = 4'hC;
    localparam logic [31:0] FLUSH_MASK = 32'hFFFF_0000;
`else
    localparam int          WEW        = 1;
    localparam logic [3:0]  WE_FULL    = 4'h1;
    localparam logic [3:0]  WE_FLUSH   = 4'h1;
    localparam logic [31:0] FLUSH_MASK = 32'hFFFF_FFFF;
`endif

    typedef struct {
        int          dut;
        bit          bank;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  we;
        logic [31:0] mask;
        int          cyc;
    } wr_t;

    logic clk;
    logic rst;
    logic bank_sel;

    logic           brst0 [2];
    logic           brst1 [2];
    logic           bclk0 [2];
    logic           bclk1 [2];
    logic           en0   [2];
    logic           en1   [2];
    logic [WEW-1:0] we0   [2];
    logic [WEW-1:0] we1   [2];
    logic [31:0]    addr0 [2];
    logic [31:0]    addr1 [2];
    logic [31:0]    din0  [2];
    logic [31:0]    din1  [2];
    logic           fd    [2];
    logic [15:0]    ww    [2];
    logic           ovf   [2];
    logic           bsy   [2];
    logic           trdy  [2];

    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;
    int  done_cnt [2];
    wr_t exp_q [$];
    wr_t mon_e;

    bram_mask_loader_if #(.DW(16)) s0 ();
    bram_mask_loader_if #(.DW(16)) s1 ();

    assign trdy[0] = s0.tready;
    assign trdy[1] = s1.tready;

    bram_mask_loader #(.DW(16), .DEPTH_WORDS(1024)) dut0 (
        .clk(clk), .rst(rst), .bank_sel(bank_sel), .m_s(s0),
        .bram_rst0(brst0[0]), .bram_rst1(brst1[0]), .bram_clk0(bclk0[0]), .bram_clk1(bclk1[0]),
        .bram_en0(en0[0]), .bram_en1(en1[0]), .bram_we0(we0[0]), .bram_we1(we1[0]),
        .bram_addr0(addr0[0]), .bram_addr1(addr1[0]), .bram_din0(din0[0]), .bram_din1(din1[0]),
        .frame_done(fd[0]), .words_written(ww[0]), .overflow(ovf[0]), .busy(bsy[0])
    );

    bram_mask_loader #(.DW(16), .DEPTH_WORDS(2)) dut1 (
        .clk(clk), .rst(rst), .bank_sel(bank_sel), .m_s(s1),
        .bram_rst0(brst0[1]), .bram_rst1(brst1[1]), .bram_clk0(bclk0[1]), .bram_clk1(bclk1[1]),
        .bram_en0(en0[1]), .bram_en1(en1[1]), .bram_we0(we0[1]), .bram_we1(we1[1]),
        .bram_addr0(addr0[1]), .bram_addr1(addr1[1]), .bram_din0(din0[1]), .bram_din1(din1[1]),
        .frame_done(fd[1]), .words_written(ww[1]), .overflow(ovf[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor / scoreboard consumer, sampling mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (fd[i] === 1'b1) done_cnt[i]++;
            if (en0[i] !== 1'b0 || en1[i] !== 1'b0 || 4'(we0[i]) !== 4'h0 || 4'(we1[i]) !== 4'h0) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_write dut=%0d en0=%b en1=%b we0=%h we1=%h addr=%h din=%h cyc=%0d",
                             i, en0[i], en1[i], we0[i], we1[i], addr0[i], din0[i], cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.dut != i
                        || en0[i] !== !mon_e.bank || en1[i] !== mon_e.bank
                        || 4'(mon_e.bank ? we1[i] : we0[i]) !== mon_e.we
                        || 4'(mon_e.bank ? we0[i] : we1[i]) !== 4'h0
                        || (mon_e.bank ? addr1[i] : addr0[i]) !== mon_e.addr
                        || ((mon_e.bank ? din1[i] : din0[i]) & mon_e.mask) !== (mon_e.din & mon_e.mask)
                        || cyc != mon_e.cyc) begin
                        mismatched++;
                        $display("FAIL bram_write got dut=%0d en0=%b en1=%b we0=%h we1=%h addr0=%h addr1=%h din0=%h din1=%h cyc=%0d required dut=%0d bank=%0d we=%h addr=%h din=%h cyc=%0d",
                                 i, en0[i], en1[i], we0[i], we1[i], addr0[i], addr1[i], din0[i], din1[i], cyc,
                                 mon_e.dut, mon_e.bank, mon_e.we, mon_e.addr, mon_e.din, mon_e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one beat into instance d and wait for it to be accepted. If wr is set, the write
    // it completes is queued to appear in the cycle right after the accepting edge.
    task automatic send(input int d, input logic [15:0] data, input bit user, input bit last,
                        input bit wr, input bit bank, input logic [31:0] addr,
                        input logic [31:0] din, input bit flush);
        int  n = 0;
        wr_t e;
        if (d == 0) begin
            s0.tdata = data; s0.tuser = user; s0.tlast = last; s0.tvalid = 1'b1;
        end else begin
            s1.tdata = data; s1.tuser = user; s1.tlast = last; s1.tvalid = 1'b1;
        end
        while (trdy[d] !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            compared++;
            mismatched++;
            $display("FAIL tready_timeout dut=%0d got tready=%b required 1", d, trdy[d]);
        end
        @(posedge clk);
        #1;
        if (wr) begin
            e.dut  = d;
            e.bank = bank;
            e.addr = addr;
            e.din  = din;
            e.we   = flush ? WE_FLUSH : WE_FULL;
            e.mask = flush ? FLUSH_MASK : 32'hFFFF_FFFF;
            e.cyc  = cyc;
            exp_q.push_back(e);
        end
        s0.tvalid = 1'b0;
        s1.tvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            compared++;
            if ({en0[i], en1[i], 4'(we0[i]), 4'(we1[i])} !== 10'd0) begin
                mismatched++;
                $display("FAIL reset_en_we dut=%0d got %b%b %h %h required all 0", i, en0[i], en1[i], we0[i], we1[i]);
            end
            compared++;
            if ({addr0[i], addr1[i], din0[i], din1[i]} !== 128'd0) begin
                mismatched++;
                $display("FAIL reset_addr_din dut=%0d got %h %h %h %h required 0", i, addr0[i], addr1[i], din0[i], din1[i]);
            end
            compared++;
            if ({fd[i], ww[i], ovf[i], bsy[i], trdy[i]} !== 20'd0) begin
                mismatched++;
                $display("FAIL reset_status dut=%0d got done=%b ww=%0d ovf=%b busy=%b tready=%b required 0",
                         i, fd[i], ww[i], ovf[i], bsy[i], trdy[i]);
            end
            compared++;
            if ({brst0[i], brst1[i], bclk0[i], bclk1[i]} !== 4'b1111) begin
                mismatched++;
                $display("FAIL reset_bram_rst_clk dut=%0d got %b%b%b%b required 1111",
                         i, brst0[i], brst1[i], bclk0[i], bclk1[i]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic frame_checks(input string name, input int d, input int d0, input int exp_done,
                                input logic [15:0] exp_ww, input logic exp_ovf);
        idle(4);
        compared++;
        if (done_cnt[d] - d0 != exp_done) begin
            mismatched++;
            $display("FAIL %s_done_pulses got %0d required %0d", name, done_cnt[d] - d0, exp_done);
        end
        compared++;
        if (ww[d] !== exp_ww) begin
            mismatched++;
            $display("FAIL %s_words_written got %0d required %0d", name, ww[d], exp_ww);
        end
        compared++;
        if (ovf[d] !== exp_ovf || bsy[d] !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_ovf_busy got ovf=%b busy=%b required ovf=%b busy=0", name, ovf[d], bsy[d], exp_ovf);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_missing_writes got %0d outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_basic;
        int d0 = done_cnt[0];
        bank_sel = 1'b0;
        send(0, 16'hA1A1, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'hB2B2, 0, 0, 1, 0, 32'd0, 32'hA1A1_B2B2, 0);
        send(0, 16'hC3C3, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'hD4D4, 0, 1, 1, 0, 32'd4, 32'hC3C3_D4D4, 0);
        compared++;
        if (fd[0] !== 1'b1 || bsy[0] !== 1'b1 || trdy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_done_state got done=%b busy=%b tready=%b required 1 1 0", fd[0], bsy[0], trdy[0]);
        end
        frame_checks("basic", 0, d0, 1, 16'd4, 1'b0);
    endtask

    task automatic test_odd_flush;
        int d0 = done_cnt[0];
        bank_sel = 1'b1;
        send(0, 16'h1111, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'h2222, 0, 0, 1, 1, 32'd0, 32'h1111_2222, 0);
        bank_sel = 1'b0;
        send(0, 16'h3333, 0, 1, 1, 1, 32'd4, 32'h3333_0000, 1);
        compared++;
        if (trdy[0] !== 1'b0 || fd[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_state got tready=%b done=%b required 0 0", trdy[0], fd[0]);
        end
        frame_checks("odd_flush", 0, d0, 1, 16'd3, 1'b0);
    endtask

    task automatic test_overflow;
        int d0 = done_cnt[1];
        bank_sel = 1'b0;
        send(1, 16'h0001, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(1, 16'h0002, 0, 0, 1, 0, 32'd0, 32'h0001_0002, 0);
        send(1, 16'h0003, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        send(1, 16'h0004, 0, 0, 1, 0, 32'd4, 32'h0003_0004, 0);
        send(1, 16'h0005, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        send(1, 16'h0006, 0, 1, 0, 0, 32'd0, 32'd0, 0);
        frame_checks("overflow", 1, d0, 1, 16'd6, 1'b1);
        d0 = done_cnt[1];
        send(1, 16'h0007, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(1, 16'h0008, 0, 1, 1, 0, 32'd0, 32'h0007_0008, 0);
        frame_checks("overflow_clear", 1, d0, 1, 16'd2, 1'b0);
    endtask

    task automatic test_restart;
        int d0 = done_cnt[0];
        bank_sel = 1'b0;
        send(0, 16'h5555, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'h6666, 0, 0, 1, 0, 32'd0, 32'h5555_6666, 0);
        bank_sel = 1'b1;
        send(0, 16'h7777, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'h8888, 0, 0, 1, 1, 32'd0, 32'h7777_8888, 0);
        send(0, 16'h9999, 0, 1, 1, 1, 32'd4, 32'h9999_0000, 1);
        frame_checks("restart_even", 0, d0, 1, 16'd3, 1'b0);
        d0 = done_cnt[0];
        bank_sel = 1'b0;
        send(0, 16'hAAAA, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'hBBBB, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'hCCCC, 0, 1, 1, 0, 32'd0, 32'hBBBB_CCCC, 0);
        frame_checks("restart_odd", 0, d0, 1, 16'd2, 1'b0);
    endtask

    task automatic test_one_word;
        int d0 = done_cnt[0];
        bank_sel = 1'b0;
        send(0, 16'hDDDD, 1, 1, 1, 0, 32'd0, 32'hDDDD_0000, 1);
        frame_checks("one_word", 0, d0, 1, 16'd1, 1'b0);
    endtask

    task automatic test_gaps;
        int d0 = done_cnt[0];
        bank_sel = 1'b1;
        send(0, 16'hA1A1, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        idle(1);
        send(0, 16'hB2B2, 0, 0, 1, 1, 32'd0, 32'hA1A1_B2B2, 0);
        idle(1);
        send(0, 16'hC3C3, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        idle(1);
        send(0, 16'hD4D4, 0, 1, 1, 1, 32'd4, 32'hC3C3_D4D4, 0);
        frame_checks("gaps", 0, d0, 1, 16'd4, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        int d0 = done_cnt[0];
        bank_sel = 1'b0;
        send(0, 16'hE1E1, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        // Beat that would complete a write, presented on the reset edge.
        s0.tdata = 16'hE2E2; s0.tuser = 1'b0; s0.tlast = 1'b0; s0.tvalid = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        s0.tvalid = 1'b0;
        compared++;
        if ({en0[0], en1[0], 4'(we0[0]), 4'(we1[0]), addr0[0], din0[0]} !== 74'd0) begin
            mismatched++;
            $display("FAIL midreset_bram got en=%b%b we=%h%h addr=%h din=%h required 0",
                     en0[0], en1[0], we0[0], we1[0], addr0[0], din0[0]);
        end
        compared++;
        if ({fd[0], ww[0], ovf[0], bsy[0], trdy[0]} !== 20'd0) begin
            mismatched++;
            $display("FAIL midreset_status got done=%b ww=%0d ovf=%b busy=%b tready=%b required 0",
                     fd[0], ww[0], ovf[0], bsy[0], trdy[0]);
        end
        rst = 1'b1;
        send(0, 16'hF1F1, 0, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'hF2F2, 0, 1, 0, 0, 32'd0, 32'd0, 0);
        compared++;
        if (bsy[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_ignored_busy got %b required 0", bsy[0]);
        end
        frame_checks("midreset_ignored", 0, d0, 0, 16'd0, 1'b0);
        bank_sel = 1'b1;
        send(0, 16'h0A0A, 1, 0, 0, 0, 32'd0, 32'd0, 0);
        send(0, 16'h0B0B, 0, 1, 1, 1, 32'd0, 32'h0A0A_0B0B, 0);
        frame_checks("midreset_recover", 0, d0, 1, 16'd2, 1'b0);
    endtask

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        rst = 1'b0;
        bank_sel = 1'b0;
        s0.tdata = '0; s0.tvalid = 1'b0; s0.tlast = 1'b0; s0.tuser = 1'b0;
        s1.tdata = '0; s1.tvalid = 1'b0; s1.tlast = 1'b0; s1.tuser = 1'b0;
        test_reset();
        test_basic();
        test_odd_flush();
        test_overflow();
        test_restart();
        test_one_word();
        test_gaps();
        test_reset_mid_frame();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bram_mask_loader.md
Name: bram_mask_loader

Overview:
- Write-side counterpart of the mask reader: accepts a mask image as a 16-bit AXI-stream and packs pairs of words into 32-bit BRAM words.
- Writes into one of two mask BRAMs (bank 0 / bank 1) through their write ports.
- Word layout matches the read side: first word of each pair goes to [31:16], second word to [15:0]; address steps by 4 bytes per 32-bit word.
- Reports frame completion, word count and overflow to the control logic.

Parameters:
DW, 16, stream data width; must be 16 (half of the 32-bit BRAM word).
DEPTH_WORDS, 1024, BRAM depth in 32-bit words; byte address limit = DEPTH_WORDS*4.

Ports:
clk  in  1  single clock for all logic and both BRAM ports
rst  in  1  synchronous, active-low reset
bank_sel  in  1  target bank; sampled only on start-of-frame accept
m_s_tdata  in  DW  mask word
m_s_tvalid  in  1  stream valid
m_s_tready  out  1  stream ready
m_s_tlast  in  1  last word of mask frame
m_s_tuser  in  1  start of mask frame
bram_rst0/bram_rst1  out  1  = ~rst (BRAM resets are active-high)
bram_clk0/bram_clk1  out  1  = clk
bram_en0/bram_en1  out  1  write strobe for the port (high together with that port's we)
bram_we0/bram_we1  out  1 (4 with MASK_BYTE_WE_EN)  write enable
bram_addr0/bram_addr1  out  32  byte address
bram_din0/bram_din1  out  32  write data
frame_done  out  1  one-cycle pulse at end of frame
words_written  out  16  count of 16-bit words stored in the last frame; held until next done
overflow  out  1  last frame exceeded DEPTH_WORDS; held until next frame start
busy  out  1  high in EVEN/ODD/FLUSH/DONE states

Behaviour:
- Reset (rst=0 at a clk edge) gives the following; reset mid-frame abandons the frame and no write is completed:
  - state IDLE
  - all bram_en/we/din/addr = 0
  - frame_done=0, words_written=0, overflow=0, busy=0, m_s_tready=0
- m_s_tready = 1 in IDLE/EVEN/ODD; 0 in FLUSH and DONE. A beat is accepted on tvalid & tready.
- States:
  - IDLE: beats without tuser are discarded.
    - Beat with tuser: latch bank_sel; clear addr, count and overflow.
    - Store tdata as the high half. Go to ODD, or to FLUSH if tlast is also set.
  - EVEN: accepted beat is stored as the high half.
    - tlast set → FLUSH; otherwise → ODD.
  - ODD: accepted beat is the low half.
    - Next cycle: one write of {hi, tdata} to the selected bank at addr; addr += 4.
    - tlast set → DONE; otherwise → EVEN.
  - FLUSH: single cycle. Writes the odd trailing word {hi, 16'h0000} at addr, then → DONE.
  - DONE: single cycle. frame_done=1, words_written updated, then → IDLE.
- Write timing: each write is registered and occurs exactly 1 cycle after the beat that completes it. en and we are high for that cycle only.
- The unselected bank sees en=0 and we=0.
- Count: increments per accepted beat in a frame; saturates at 16'hFFFF.
- Overflow: once addr == DEPTH_WORDS*4:
  - no further writes are issued and addr holds;
  - beats are still accepted and counted;
  - overflow=1;
  - tlast still ends the frame normally.
- tuser in EVEN or ODD: restart the frame.
  - Any pending high half is dropped and no write is issued for it.
  - Re-latch bank_sel; clear addr, count and overflow.
  - The beat becomes the first high half.
  - No frame_done is pulsed for the aborted frame.
- tuser and tlast on the same beat: one-word frame. Goes through FLUSH, then DONE with words_written=1.
- tvalid low in any state: hold the state; no write.

Optional Feature:
- Macro MASK_BYTE_WE_EN.
- Defined:
  - bram_we0/1 are 4 bits.
  - Full writes use 4'b1111.
  - The FLUSH write uses 4'b1100, so [15:0] of the BRAM word is left untouched; bram_din[15:0] is don't-care.
- Undefined:
  - bram_we0/1 are 1 bit.
  - The FLUSH write zero-fills [15:0].

Test Plan:
- Frame of 4 beats A1A1, B2B2, C3C3, D4D4 (tuser on the first, tlast on the last) to bank 0 → two writes: addr 0 din A1A1B2B2, addr 4 din C3C3D4D4; bank 1 idle; frame_done pulse, words_written=4.
- 3-beat frame 1111, 2222, 3333 to bank 1 → addr 0 = 11112222, addr 4 = 33330000 (we=1100 with MASK_BYTE_WE_EN); words_written=3.
- DEPTH_WORDS=2, 6-beat frame → only addr 0 and 4 written; overflow=1; words_written=6; frame_done pulses once.
- tuser re-asserted on beat 3 of a frame (after one completed write), bank_sel flipped → aborted frame gets no done; new frame starts at addr 0 on the new bank; the first write contains the restart beat in [31:16].
- tvalid toggled 1-0-1-0 every cycle over a 4-beat frame → same BRAM contents as the gapless case; each write occurs 1 cycle after its completing beat.
- Reset asserted while in ODD → next cycle all outputs 0, state IDLE; non-tuser beats that follow are ignored until the next tuser.
